// File: rtl/mc_scpu_ctrl.sv
// mc_scpu_ctrl: multi-cycle control unit for a small RV32I subset (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional memory-wait timeout is enabled by defining MC_SCPU_CTRL_TIMEOUT_EN.
module mc_scpu_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int STATE_W      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         OPcode,
    input  logic [2:0]         Fun3,
    input  logic               Fun7,
    input  logic               MIO_ready,
    input  logic               zero,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemRW,
    output logic               CPU_MIO,
    output logic [2:0]         ImmSel,
    output logic [1:0]         ALUSrc_A,
    output logic [1:0]         ALUSrc_B,
    output logic [1:0]         MemtoReg,
    output logic               PCSrc,
    output logic [3:0]         ALU_Control,
    output logic [STATE_W-1:0] state,
    output logic               illegal,
    output logic               bus_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal_op = 1'b1;
            default:                           is_legal_op = 1'b0;
        endcase
    endfunction

    // Immediate-form ops have no sub; Fun7 only selects srai over srli.
    function automatic logic [3:0] ri_alu_ctrl(input logic [4:0] op, input logic [2:0] f3,
                                               input logic f7);
        if (op == OP_R) begin
            ri_alu_ctrl = {f7, f3};
        end else if (f3 == 3'b101) begin
            ri_alu_ctrl = {f7, f3};
        end else begin
            ri_alu_ctrl = {1'b0, f3};
        end
    endfunction

    function automatic logic is_cond_supported(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001: is_cond_supported = 1'b1;
            default:        is_cond_supported = 1'b0;
        endcase
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic       illegal_r;
    logic       set_illegal_s;
    logic       branch_taken_s;
    logic       wait_expired_s;

    logic       pc_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       mem_rw_s;
    logic       cpu_mio_s;
    logic [2:0] imm_sel_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] mem_to_reg_s;
    logic       pc_src_s;
    logic [3:0] alu_ctrl_s;

`ifdef MC_SCPU_CTRL_TIMEOUT_EN
    localparam int WAIT_W = (MEM_WAIT_MAX > 2) ? $clog2(MEM_WAIT_MAX) : 1;

    logic [WAIT_W-1:0] wait_cnt_r;
    logic              stall_s;
    logic              bus_err_r;

    assign stall_s        = ((state_r == S_FETCH) || (state_r == S_MEM)) && !MIO_ready;
    assign wait_expired_s = (wait_cnt_r == WAIT_W'(MEM_WAIT_MAX - 1));

    // Consecutive stall cycles within one FETCH/MEM visit; any state change restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (stall_s && (state_nxt_s == state_r)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end

    // Sticky bus error, raised on the stall cycle that exhausts the budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_r <= 1'b0;
        end else if (stall_s && wait_expired_s) begin
            bus_err_r <= 1'b1;
        end else begin
            bus_err_r <= bus_err_r;
        end
    end

    assign bus_err = bus_err_r;
`else
    assign wait_expired_s = 1'b0;
    assign bus_err        = 1'b0;
`endif

    // Branch resolution for the two supported conditions (beq, bne).
    always_comb begin
        branch_taken_s = 1'b0;
        case (Fun3)
            3'b000:  branch_taken_s = zero;
            3'b001:  branch_taken_s = !zero;
            default: branch_taken_s = 1'b0;
        endcase
    end

    // Next-state and strobe decode; strobes are forced low while reset is held.
    always_comb begin
        state_nxt_s   = state_r;
        set_illegal_s = 1'b0;
        pc_write_s    = 1'b0;
        ir_write_s    = 1'b0;
        reg_write_s   = 1'b0;
        mem_rw_s      = 1'b0;
        cpu_mio_s     = 1'b0;
        imm_sel_s     = IMM_I;
        alu_src_a_s   = SRC_A_RS1;
        alu_src_b_s   = SRC_B_RS2;
        mem_to_reg_s  = WB_ALU;
        pc_src_s      = 1'b0;
        alu_ctrl_s    = ALU_ADD;
        if (rst_n) begin
            case (state_r)
                S_FETCH: begin
                    cpu_mio_s = 1'b1;
                    if (MIO_ready) begin
                        ir_write_s  = 1'b1;
                        pc_write_s  = 1'b1;
                        state_nxt_s = S_DECODE;
                    end else if (wait_expired_s) begin
                        state_nxt_s = S_HALT;
                    end else begin
                        state_nxt_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    if (is_legal_op(OPcode)) begin
                        state_nxt_s = S_EXEC;
                    end else begin
                        set_illegal_s = 1'b1;
                        state_nxt_s   = S_HALT;
                    end
                end
                S_EXEC: begin
                    case (OPcode)
                        OP_R: begin
                            alu_ctrl_s  = ri_alu_ctrl(OPcode, Fun3, Fun7);
                            state_nxt_s = S_WB;
                        end
                        OP_I: begin
                            alu_ctrl_s  = ri_alu_ctrl(OPcode, Fun3, Fun7);
                            alu_src_b_s = SRC_B_IMM;
                            state_nxt_s = S_WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_b_s = SRC_B_IMM;
                            imm_sel_s   = (OPcode == OP_STORE) ? IMM_S : IMM_I;
                            state_nxt_s = S_MEM;
                        end
                        OP_BRANCH: begin
                            alu_ctrl_s = ALU_SUB;
                            imm_sel_s  = IMM_B;
                            if (is_cond_supported(Fun3)) begin
                                pc_write_s  = branch_taken_s;
                                pc_src_s    = branch_taken_s;
                                state_nxt_s = S_FETCH;
                            end else begin
                                set_illegal_s = 1'b1;
                                state_nxt_s   = S_HALT;
                            end
                        end
                        OP_JAL, OP_JALR: begin
                            imm_sel_s   = (OPcode == OP_JAL) ? IMM_J : IMM_I;
                            alu_src_a_s = (OPcode == OP_JAL) ? SRC_A_PC : SRC_A_RS1;
                            alu_src_b_s = SRC_B_IMM;
                            pc_write_s  = 1'b1;
                            pc_src_s    = 1'b1;
                            state_nxt_s = S_WB;
                        end
                        OP_LUI, OP_AUIPC: begin
                            imm_sel_s   = IMM_U;
                            alu_src_a_s = (OPcode == OP_LUI) ? SRC_A_ZERO : SRC_A_PC;
                            alu_src_b_s = SRC_B_IMM;
                            state_nxt_s = S_WB;
                        end
                        default: begin
                            set_illegal_s = 1'b1;
                            state_nxt_s   = S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    cpu_mio_s = 1'b1;
                    mem_rw_s  = (OPcode == OP_STORE);
                    if (MIO_ready) begin
                        state_nxt_s = (OPcode == OP_STORE) ? S_FETCH : S_WB;
                    end else if (wait_expired_s) begin
                        state_nxt_s = S_HALT;
                    end else begin
                        state_nxt_s = S_MEM;
                    end
                end
                S_WB: begin
                    reg_write_s = 1'b1;
                    case (OPcode)
                        OP_LOAD:          mem_to_reg_s = WB_MEM;
                        OP_JAL, OP_JALR:  mem_to_reg_s = WB_PC4;
                        default:          mem_to_reg_s = WB_ALU;
                    endcase
                    state_nxt_s = S_FETCH;
                end
                S_HALT: begin
                    state_nxt_s = S_HALT;
                end
                default: begin
                    state_nxt_s = S_FETCH;
                end
            endcase
        end else begin
            state_nxt_s = S_FETCH;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sticky illegal-instruction flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (set_illegal_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign state       = STATE_W'(state_r);
    assign illegal     = illegal_r;
    assign PCWrite     = pc_write_s;
    assign IRWrite     = ir_write_s;
    assign RegWrite    = reg_write_s;
    assign MemRW       = mem_rw_s;
    assign CPU_MIO     = cpu_mio_s;
    assign ImmSel      = imm_sel_s;
    assign ALUSrc_A    = alu_src_a_s;
    assign ALUSrc_B    = alu_src_b_s;
    assign MemtoReg    = mem_to_reg_s;
    assign PCSrc       = pc_src_s;
    assign ALU_Control = alu_ctrl_s;

endmodule
